// File: rtl/ldpc_enc_sched.sv
// ldpc_enc_sched: shares one bit-serial systematic LDPC encoder among NREQ requesters.
//
// A round-robin arbiter grants one requester per word. The granted info word is
// multiplied by the K x (N-K) parity sub-matrix P one row per cycle (K cycles).
// The codeword {info, parity} is then held on a valid/ready output until it is accepted.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   cfg_we        write row cfg_row of P with cfg_data
//   cfg_row       row index j; cfg_data bit i = P[j][i]
//   cfg_err       sticky flag, set when a write is dropped (during ENC or row >= K)
//   req_valid     per-requester word valid
//   req_info      requester r word at [r*K +: K]
//   req_ready     one-hot grant, only in IDLE
//   out_valid     codeword valid
//   out_ready     sink accepts the codeword
//   out_codeword  {info, parity}
//   out_src       index of the requester that supplied out_codeword
//   busy          scheduler is not idle
module ldpc_enc_sched #(
    parameter int unsigned N    = 6,
    parameter int unsigned K    = 3,
    parameter int unsigned NREQ = 2,
    localparam int unsigned RW  = (K > 1) ? $clog2(K) : 1,
    localparam int unsigned SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [RW-1:0]     cfg_row,
    input  logic [N-K-1:0]    cfg_data,
    output logic              cfg_err,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*K-1:0] req_info,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_codeword,
    output logic [SW-1:0]     out_src,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StEnc, StOut} state_e;

    state_e           state_q;
    logic [N-K-1:0]   p_q [K];
    logic [K-1:0]     info_q;
    logic [N-K-1:0]   acc_q;
    logic [RW-1:0]    cnt_q;
    logic [SW-1:0]    last_grant_q;

    logic [SW-1:0]    grant;
    logic             grant_found;
    logic [K-1:0]     grant_info;
    int unsigned      best_off;
    int unsigned      off;
    logic [N-K-1:0]   acc_next;
    logic             cfg_ok;

    // Round-robin: the valid requester with the smallest cyclic distance past
    // last_grant_q wins.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        grant_info  = '0;
        best_off    = NREQ;
        off         = 0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            off = (r + NREQ - 32'(last_grant_q) - 1) % NREQ;
            if (req_valid[r] && (off < best_off)) begin
                best_off    = off;
                grant       = SW'(r);
                grant_info  = req_info[r*K +: K];
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if ((state_q == StIdle) && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign acc_next = acc_q ^ (info_q[cnt_q] ? p_q[cnt_q] : '0);
    // P is only stable-critical while ENC is reading it row by row.
    assign cfg_ok   = cfg_we && (state_q != StEnc) && (32'(cfg_row) < K);
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            for (int i = 0; i < K; i++) begin
                p_q[i] <= '0;
            end
            cfg_err      <= 1'b0;
            out_valid    <= 1'b0;
            out_codeword <= '0;
            out_src      <= '0;
            info_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            last_grant_q <= SW'(NREQ - 1);
        end else begin
            if (cfg_ok) begin
                p_q[cfg_row] <= cfg_data;
            end else if (cfg_we) begin
                cfg_err <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        info_q       <= grant_info;
                        out_src      <= grant;  // out_valid is low, so no visible glitch
                        last_grant_q <= grant;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        state_q      <= StEnc;
                    end
                end
                StEnc: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (32'(cnt_q) == K - 1) begin
                        out_valid    <= 1'b1;
                        out_codeword <= {info_q, acc_next};
                        state_q      <= StOut;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_enc_sched.sv
// Self-checking bench for ldpc_enc_sched (N=6, K=3, NREQ=2).
// A transaction-level model predicts grants, timing, codewords and cfg_err;
// directed vectors add hand-computed literal expectations.
module tb_ldpc_enc_sched;

    localparam int N    = 6;
    localparam int K    = 3;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_row = '0;
    logic [N-K-1:0]    cfg_data = '0;
    logic              cfg_err;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*K-1:0] req_info = '0;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N-1:0]      out_codeword;
    logic [0:0]        out_src;
    logic              busy;

    ldpc_enc_sched #(.N(N), .K(K), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_row      (cfg_row),
        .cfg_data     (cfg_data),
        .cfg_err      (cfg_err),
        .req_valid    (req_valid),
        .req_info     (req_info),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_src      (out_src),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [N-K-1:0] m_p [K];
    bit             m_idle = 1'b1;
    bit             m_err  = 1'b0;
    int             m_hs   = 0;
    int             m_src  = 0;
    int             m_lg   = NREQ - 1;
    logic [N-1:0]   m_cw   = '0;

    function automatic logic [N-K-1:0] parity_of(input logic [K-1:0] info);
        logic [N-K-1:0] p = '0;
        for (int i = 0; i < N - K; i++)
            for (int j = 0; j < K; j++)
                p[i] = p[i] ^ (info[j] & m_p[j][i]);
        return p;
    endfunction

    int              g;
    int              r;
    bit              vnow;
    logic [NREQ-1:0] exp_ready;

    always @(negedge clk) begin
        if (rst) begin
            m_idle = 1'b1;
            m_err  = 1'b0;
            m_lg   = NREQ - 1;
            for (int j = 0; j < K; j++) m_p[j] = '0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_codeword", out_codeword, 0);
            chk("rst_out_src", out_src, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_cfg_err", cfg_err, 0);
        end else begin
            g = -1;
            for (int i = 1; i <= NREQ; i++) begin
                r = (m_lg + i) % NREQ;
                if (g < 0 && req_valid[r]) g = r;
            end
            exp_ready = '0;
            if (m_idle && g >= 0) exp_ready[g] = 1'b1;
            vnow = !m_idle && (cyc >= m_hs + K + 1);

            chk("req_ready", req_ready, exp_ready);
            chk("out_valid", out_valid, vnow);
            chk("busy", busy, !m_idle);
            chk("cfg_err", cfg_err, m_err);
            if (vnow) begin
                chk("out_codeword", out_codeword, m_cw);
                chk("out_src", out_src, m_src);
            end

            // next-cycle model state
            if (cfg_we) begin
                if ((!m_idle && !vnow) || cfg_row >= K) m_err = 1'b1;
                else m_p[cfg_row] = cfg_data;
            end
            if (m_idle && g >= 0) begin
                m_idle = 1'b0;
                m_hs   = cyc;
                m_src  = g;
                m_lg   = g;
                m_cw   = {req_info[g*K +: K], parity_of(req_info[g*K +: K])};
            end else if (vnow && out_ready) begin
                m_idle = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] row, input logic [N-K-1:0] data);
        cfg_we   = 1'b1;
        cfg_row  = row;
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
    endtask

    // Returns at the first cycle with out_valid high (not yet accepted).
    task automatic send(input int rq, input logic [K-1:0] info, input bit enc_cfg,
                        output int lat, output logic [N-1:0] cw, output int src);
        int n;
        int t0;
        req_info[rq*K +: K] = info;
        req_valid[rq]       = 1'b1;
        #1;
        n = 0;
        while (!req_ready[rq] && n < 20) begin
            step();
            n++;
        end
        if (!req_ready[rq]) begin
            $display("FAIL grant_wait: req_ready[%0d] got 0 after 20 cycles, expected 1", rq);
            total_cnt++;
            req_valid[rq] = 1'b0;
            lat = -1;
            cw  = '0;
            src = -1;
            return;
        end
        t0 = cyc;
        step();
        req_valid[rq] = 1'b0;
        if (enc_cfg) begin
            cfg_we   = 1'b1;
            cfg_row  = 2'd1;
            cfg_data = '0;
            step();
            cfg_we   = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        lat = cyc - t0;
        cw  = out_codeword;
        src = out_src;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int           lat;
        int           src;
        logic [N-1:0] cw;
        int           srcs [4];
        int           when [4];
        int           nseen;
        int           n;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", busy, 0);

        cfg_write(2'd0, 3'b011);
        cfg_write(2'd1, 3'b101);
        cfg_write(2'd2, 3'b110);
        chk("cfg_err_clean", cfg_err, 0);

        send(0, 3'b010, 1'b0, lat, cw, src);
        chk("lat_010", lat, 4);
        chk("cw_010", cw, 6'h15);
        chk("src_010", src, 0);
        step();
        send(0, 3'b111, 1'b0, lat, cw, src);
        chk("cw_111", cw, 6'h38);
        step();
        send(0, 3'b101, 1'b0, lat, cw, src);
        chk("cw_101", cw, 6'h2D);
        step();
        send(1, 3'b000, 1'b0, lat, cw, src);
        chk("cw_000", cw, 6'h00);
        chk("src_000", src, 1);
        step();

        // both requesters continuously valid
        req_info  = {3'b101, 3'b010};
        req_valid = 2'b11;
        #1;
        nseen = 0;
        for (int k = 0; k < 40 && nseen < 4; k++) begin
            if (out_valid) begin
                srcs[nseen] = out_src;
                when[nseen] = cyc;
                nseen++;
                if (nseen == 4) req_valid = '0;
            end
            step();
        end
        chk("rot_count", nseen, 4);
        for (int i = 0; i < nseen; i++) begin
            chk("rot_src", srcs[i], i % 2);
            if (i > 0) chk("rot_gap", when[i] - when[i-1], 5);
        end

        // backpressure with a config write while holding OUT
        out_ready = 1'b0;
        send(0, 3'b010, 1'b0, lat, cw, src);
        chk("bp_cw_first", cw, 6'h15);
        req_info[5:3] = 3'b111;
        req_valid[1]  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("bp_cw", out_codeword, 6'h15);
            chk("bp_src", out_src, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_no_ready", req_ready, 0);
            if (k == 3) begin
                cfg_we   = 1'b1;
                cfg_row  = 2'd1;
                cfg_data = 3'b111;
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_busy", busy, 0);
        req_valid = '0;
        cfg_write(2'd1, 3'b101);

        // write during ENC is dropped
        send(0, 3'b010, 1'b1, lat, cw, src);
        chk("enc_cfg_cw", cw, 6'h15);
        chk("enc_cfg_err", cfg_err, 1);
        step();
        send(0, 3'b010, 1'b0, lat, cw, src);
        chk("enc_cfg_p_kept", cw, 6'h15);
        step();

        // asynchronous reset in the middle of ENC
        req_info[2:0] = 3'b111;
        req_valid     = 2'b01;
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin
            step();
            n++;
        end
        chk("ar_grant", req_ready[0], 1);
        step();
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_cw", out_codeword, 0);
        chk("ar_cfg_err", cfg_err, 0);
        chk("ar_ready", req_ready, 0);
        step();
        step();
        rst = 1'b0;

        req_info  = {3'b101, 3'b010};
        req_valid = 2'b11;
        #1;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("post_rst_src", out_src, 0);
        chk("post_rst_cw_p_zero", out_codeword, 6'h10);
        req_valid = '0;
        step();

        // out-of-range row
        cfg_write(2'd0, 3'b011);
        cfg_write(2'd1, 3'b101);
        cfg_write(2'd2, 3'b110);
        chk("row_ok_err", cfg_err, 0);
        cfg_write(2'd3, 3'b000);
        chk("row3_err", cfg_err, 1);
        send(0, 3'b010, 1'b0, lat, cw, src);
        chk("row3_p_kept", cw, 6'h15);
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ldpc_enc_sched.md
Name: ldpc_enc_sched

Overview:
- Scheduler/controller that shares one systematic LDPC encoder datapath among NREQ requesters.
- Holds the K x (N-K) parity sub-matrix P in a configuration register file.
- Arbitrates requests round-robin and sequences a bit-serial parity accumulation over K cycles.
- Presents the codeword on a valid/ready output. Sits between the info-word sources and the downstream codeword sink.

Parameters:
- N, 6, codeword length
- K, 3, information bits per word (K >= 1, K < N)
- NREQ, 2, number of requesters (NREQ >= 1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- cfg_we  input  1  write one row of P
- cfg_row  input  max(1,$clog2(K))  row index j being written
- cfg_data  input  N-K  row value; bit i = P[j][i]
- cfg_err  output  1  sticky: a cfg write was dropped
- req_valid  input  NREQ  per-requester info word valid
- req_info  input  NREQ*K  requester r word at [r*K +: K]
- req_ready  output  NREQ  per-requester accept
- out_valid  output  1  codeword valid
- out_ready  input  1  sink accepts codeword
- out_codeword  output  N  {info, parity}
- out_src  output  max(1,$clog2(NREQ))  requester index of out_codeword
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1) clears the following to 0:
  - state = IDLE
  - all P rows, cfg_err
  - out_valid, out_codeword, out_src
  - req_ready = 0
  - bit counter and accumulator
- Reset also sets last_grant = NREQ-1, so requester 0 has first priority. Reset mid-operation discards the in-flight word.
- Each FSM step below is one clk cycle:
  - IDLE:
    - Grant g = first r with req_valid[r]=1, searching cyclically from last_grant+1.
    - req_ready[g]=1 combinationally; all other req_ready bits are 0. req_ready is 0 in every other state.
    - On handshake (req_valid[g] & req_ready[g]): latch info=req_info[g], src=g, last_grant=g; clear acc and cnt; go to ENC.
    - If no req_valid, stay in IDLE.
  - ENC:
    - Each cycle: if info[cnt], then acc <= acc ^ P[cnt]; cnt <= cnt+1.
    - When cnt==K-1, go to OUT after this update (exactly K cycles in ENC).
  - OUT:
    - out_valid=1; out_codeword = {info, acc}, i.e. codeword[N-1:N-K]=info and codeword[N-K-1:0]=parity.
    - parity[i] = XOR over j of (info[j] & P[j][i]).
    - out_codeword and out_src are held stable while out_valid=1 and out_ready=0.
    - On out_valid & out_ready: out_valid <= 0 and go to IDLE. A new grant can occur no earlier than the next cycle.
- Latency: handshake at cycle t gives out_valid high from cycle t+K+1. Throughput is at most one word per K+2 cycles.
- req_valid may drop without handshake; the arbiter re-evaluates each IDLE cycle. A granted requester with no handshake does not update last_grant.
- Config writes:
  - cfg_we in IDLE or OUT writes P[cfg_row] <= cfg_data at the clock edge.
  - cfg_we in ENC is dropped (P unchanged) and sets cfg_err=1 until reset.
  - cfg_row >= K is dropped and sets cfg_err.
  - A write in OUT does not change the held out_codeword.
  - A write in the same cycle as an IDLE handshake takes effect for that word, since ENC reads P from the next cycle.
- All-zero info, or all-zero P, gives parity 0.
- All requesters valid: grants rotate 0,1,...,NREQ-1,0 with no starvation.

Test Plan:
- Config/encode, N=6,K=3,NREQ=2, P rows 0..2 = 011,101,110:
  - requester 0 info=3'b010 gives out_codeword=6'h15 and out_src=0.
  - out_valid rises exactly 4 cycles after the handshake.
- Same P, info=3'b111 -> 6'h38; info=3'b101 -> 6'h2D; info=3'b000 -> 6'h00.
- Both req_valid held high with out_ready=1:
  - grants alternate src 0,1,0,1.
  - req_ready one-hot, only in IDLE.
  - successive out_valid pulses 5 cycles apart.
- Backpressure: out_ready=0 for 10 cycles in OUT:
  - out_codeword and out_src stay stable, no new req_ready.
  - raising out_ready completes the transfer and returns to IDLE.
- cfg_we during ENC, and cfg_we with cfg_row=3:
  - P unchanged, cfg_err=1, current codeword unaffected.
- Assert rst mid-ENC:
  - outputs and P asynchronously cleared, busy=0.
  - after release, requester 0 wins the first grant when both are valid.
